chunk_add: RTL and testbench

CHUNK_ADD -- requirements
Module: chunk_add

---
 rtl/chunk_add.sv | 144 ++++++++++++++
 tb/tb_chunk_add.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/chunk_add.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// and publishes z/c_out/ovf/zero together when the last chunk completes.
module chunk_add #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK:0]   chunk_s;
  logic [WIDTH-1:0] sum_next_s;
  logic             last_s;

  // The carry into the MSB is recovered from the MSB sum bit (s = a ^ b ^ cin).
  function automatic logic ovf_f(input logic cout, input logic a_msb,
                                 input logic b_msb, input logic s_msb);
    return cout ^ (a_msb ^ b_msb ^ s_msb);
  endfunction

  // Chunk adder on the low chunk of the shifting operands; sum fills from the top.
  always_comb begin
    chunk_s    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    sum_next_s = (sum_q >> CHUNK) | (WIDTH'(chunk_s[CHUNK-1:0]) << (WIDTH - CHUNK));
    last_s     = (idx_q == IW'(N - 1));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    z_d     = z_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = x;
          b_d     = sub ? ~y : y;
          carry_d = sub ? 1'b1 : c_in;
          idx_d   = {IW{1'b0}};
          sum_d   = {WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_s[CHUNK];
        sum_d   = sum_next_s;
        idx_d   = idx_q + IW'(1);
        if (last_s) begin
          state_d = DONE;
          idx_d   = {IW{1'b0}};
          z_d     = sum_next_s;
          c_out_d = chunk_s[CHUNK];
          ovf_d   = ovf_f(chunk_s[CHUNK], a_q[CHUNK-1], b_q[CHUNK-1], chunk_s[CHUNK-1]);
          zero_d  = (sum_next_s == {WIDTH{1'b0}});
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      idx_q   <= {IW{1'b0}};
      z_q     <= {WIDTH{1'b0}};
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      z_q     <= z_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign z     = z_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_chunk_add.sv
// Directed bench for chunk_add: a vector table on a 32/8 instance plus
// hand-written sequences for interference, reset abort and the N=1 case.
module tb_chunk_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, c_in;
  logic [31:0] x, y;
  logic        busy, done, c_out, ovf, zero;
  logic [31:0] z;

  logic        start2, sub2, c_in2;
  logic [15:0] x2, y2;
  logic        busy2, done2, c_out2, ovf2, zero2;
  logic [15:0] z2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chunk_add #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .x(x), .y(y), .c_in(c_in),
    .busy(busy), .done(done), .z(z), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  chunk_add #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .x(x2), .y(y2), .c_in(c_in2),
    .busy(busy2), .done(done2), .z(z2), .c_out(c_out2), .ovf(ovf2), .zero(zero2)
  );

  typedef struct {
    logic        sub;
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [31:0] ez;
    logic        ec;
    logic        eo;
    logic        ezero;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input logic ci);
    sub   = s;
    x     = a;
    y     = b;
    c_in  = ci;
    start = 1'b1;
  endtask

  // Waits for done after the accepting edge, scrambling inputs and poking start meanwhile.
  task automatic finish_op(input string tag, input logic [31:0] ez, input logic ec,
                           input logic eo, input logic ezero);
    int          cnt;
    logic [31:0] prev_z;
    prev_z = z;
    @(posedge clk); #1;
    start = 1'b0;
    x     = ~x;
    y     = ~y;
    sub   = ~sub;
    c_in  = ~c_in;
    cnt   = 1;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && cnt < 20) begin
      if (cnt == 2) begin
        start = 1'b1;
        x     = 32'hA5A5A5A5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
      if (done !== 1'b1) chk({tag, "_zhold"}, z, prev_z);
    end
    start = 1'b0;
    chk({tag, "_latency"}, cnt, 32'd5);
    chk({tag, "_z"}, z, ez);
    chk({tag, "_cout"}, {31'd0, c_out}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ezero});
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_zkeep"}, z, ez);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'h12345678, 32'h0FEDCBA9, 1'b0, 32'h22222221, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h00FFFFFF, 32'h00000000, 1'b1, 32'h01000000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; x = 32'd0; y = 32'd0;
    start2 = 1'b0; sub2 = 1'b0; c_in2 = 1'b0; x2 = 16'd0; y2 = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_z", z, 32'd0);
    chk("rst_flags", {29'd0, c_out, ovf, zero}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      launch(tbl[i].sub, tbl[i].x, tbl[i].y, tbl[i].cin);
      finish_op($sformatf("vec%0d", i), tbl[i].ez, tbl[i].ec, tbl[i].eo, tbl[i].ezero);
    end

    // Reset asserted after two chunks: everything clears at once and no done follows.
    @(negedge clk);
    launch(1'b0, 32'h11111111, 32'h22222222, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_z", z, 32'd0);
    chk("abort_flags", {29'd0, c_out, ovf, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {30'd0, busy, done}, 32'd0);
    end

    // Start presented on the very first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    launch(1'b0, 32'd3, 32'd4, 1'b0);
    finish_op("post_rst", 32'd7, 1'b0, 1'b0, 1'b0);

    // Single-chunk instance: done on the second edge counting the accepting one.
    @(negedge clk);
    x2 = 16'h8000; y2 = 16'h8000; sub2 = 1'b0; c_in2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("n1_busy", {31'd0, busy2}, 32'd1);
    chk("n1_early", {31'd0, done2}, 32'd0);
    @(posedge clk); #1;
    chk("n1_done", {31'd0, done2}, 32'd1);
    chk("n1_z", {16'd0, z2}, 32'd0);
    chk("n1_flags", {29'd0, c_out2, ovf2, zero2}, 32'd7);
    @(posedge clk); #1;
    chk("n1_idle", {30'd0, busy2, done2}, 32'd0);
    @(negedge clk);
    x2 = 16'h7FFF; y2 = 16'h0001; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    chk("n1b_done", {31'd0, done2}, 32'd1);
    chk("n1b_z", {16'd0, z2}, 32'h8000);
    chk("n1b_flags", {29'd0, c_out2, ovf2, zero2}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
